io_sample_pipe: RTL and testbench

- Parametrised successor to the single-stage input register at the top level.
- Samples a WIDTH-bit input bus into a DEPTH-stage delay line, then presents it on one output bus in one of four runtime modes: registered, programmable delay, freeze/hold, change-detect.
- Tracks output validity and counts input transitions in a saturating counter.
- Sits between the dedicated input pins and the output pins of the tile top level.

---
 rtl/io_pipe_pkg.sv | 23 ++
 rtl/io_sample_pipe_sat_counter.sv | 23 ++
 rtl/io_sample_pipe.sv | 106 ++++++++++
 tb/tb_io_sample_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pipe_pkg.sv
// io_sample_pipe shared definitions.
// Output mode encodings and delay clamp helper.
package io_pipe_pkg;

    localparam logic [1:0] MODE_REG    = 2'd0;
    localparam logic [1:0] MODE_DELAY  = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_CHANGE = 2'd3;

    // Maps a requested delay onto the legal range 1..depth.
    function automatic int unsigned clamp_delay(
        input int unsigned sel,
        input int unsigned depth
    );
        if (sel == 0)
            return 1;
        else if (sel > depth)
            return depth;
        else
            return sel;
    endfunction

endpackage

// File: rtl/io_sample_pipe_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear takes priority over increment.
module sat_counter
    import io_pipe_pkg::*;
#(
    parameter int         W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != MAX))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/io_sample_pipe.sv
// Input sampling delay line with selectable output mode,
// validity tracking and saturating transition counter.
module io_sample_pipe
    import io_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8,
    parameter int DSEL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  din,
    input  logic [1:0]        mode,
    input  logic [DSEL_W-1:0] delay_sel,
    input  logic              clr_count,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  chg_count
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  stage [DEPTH];
    logic [FILL_W-1:0] fill;
    int unsigned       d_eff;
    logic [IDX_W-1:0]  d_idx;
    logic [WIDTH-1:0]  live_dout;
    logic              live_valid;
    logic [WIDTH-1:0]  hold_reg;
    logic              hold_valid;
    logic              chg_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    sat_counter #(
        .W   (FILL_W),
        .MAX (FILL_W'(DEPTH))
    ) u_fill (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (en),
        .cnt (fill)
    );

    assign d_eff = clamp_delay(32'(delay_sel), DEPTH);
    assign d_idx = IDX_W'(d_eff - 1);

    // Non-HOLD view of the pipe; also what hold_reg captures.
    always_comb begin
        live_dout  = '0;
        live_valid = 1'b0;
        unique case (1'b1)
            (mode == MODE_DELAY): begin
                live_dout  = stage[d_idx];
                live_valid = 32'(fill) >= d_eff;
            end
            (mode == MODE_CHANGE): begin
                live_dout  = stage[0] ^ stage[1];
                live_valid = fill >= FILL_W'(2);
            end
            default: begin
                live_dout  = stage[0];
                live_valid = fill != '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (mode != MODE_HOLD) begin
            hold_reg   <= live_dout;
            hold_valid <= live_valid;
        end
    end

    assign dout       = (mode == MODE_HOLD) ? hold_reg   : live_dout;
    assign dout_valid = (mode == MODE_HOLD) ? hold_valid : live_valid;

    assign chg_inc = en && (fill != '0) && (din != stage[0]);

    sat_counter #(
        .W (CNT_W)
    ) u_chg (
        .clk (clk),
        .rst (rst),
        .clr (clr_count),
        .inc (chg_inc),
        .cnt (chg_count)
    );

endmodule

// File: tb/tb_io_sample_pipe.sv
// Self-checking bench for io_sample_pipe.
// Scoreboard queue of expected outputs per scenario.
module tb_io_sample_pipe;
    import io_pipe_pkg::*;

    typedef struct {
        logic [7:0] dout;
        logic       valid;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic [1:0] mode = MODE_REG;
    logic [3:0] delay_sel = '0;
    logic       clr_count = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] chg_count;
    logic [7:0] dout2;
    logic       dout_valid2;
    logic [1:0] chg_count2;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    io_sample_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .mode       (mode),
        .delay_sel  (delay_sel),
        .clr_count  (clr_count),
        .dout       (dout),
        .dout_valid (dout_valid),
        .chg_count  (chg_count)
    );

    io_sample_pipe #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .mode       (mode),
        .delay_sel  (delay_sel),
        .clr_count  (clr_count),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .chg_count  (chg_count2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        clr_count = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b1; din = 8'hFF; mode = MODE_REG;
        e = '{8'h00, 1'b0, 8'h00};
        sb.push_back(e);
        tick(); tick();
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout) begin
            errors++;
            $display("FAIL reset_dout got=%h exp=%h", dout, e.dout);
        end
        checks++;
        if (dout_valid !== e.valid) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=%b", dout_valid, e.valid);
        end
        checks++;
        if (chg_count !== e.cnt) begin
            errors++;
            $display("FAIL reset_cnt got=%h exp=%h", chg_count, e.cnt);
        end
        rst = 1'b0; din = 8'hA5;
        sb.push_back('{8'hA5, 1'b1, 8'h00});
        tick();
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || dout_valid !== e.valid) begin
            errors++;
            $display("FAIL reset_first got=%h/%b exp=%h/%b",
                     dout, dout_valid, e.dout, e.valid);
        end
    endtask

    task automatic test_delay();
        exp_t e;
        int sels[3] = '{4, 0, 9};
        int runs[3] = '{8, 3, 9};
        for (int s = 0; s < 3; s++) begin
            int d;
            do_reset();
            mode = MODE_DELAY;
            delay_sel = 4'(sels[s]);
            d = (sels[s] == 0) ? 1 : (sels[s] > 8 ? 8 : sels[s]);
            en = 1'b1;
            for (int k = 1; k <= runs[s]; k++) begin
                din = 8'(k);
                e.dout  = (k >= d) ? 8'(k - d + 1) : 8'h00;
                e.valid = (k >= d);
                e.cnt   = 8'h00;
                sb.push_back(e);
                tick();
                e = sb.pop_front();
                checks++;
                if (dout !== e.dout || dout_valid !== e.valid) begin
                    errors++;
                    $display("FAIL delay sel=%0d k=%0d got=%h/%b exp=%h/%b",
                             sels[s], k, dout, dout_valid, e.dout, e.valid);
                end
            end
        end
        // pipe now holds 9,8,...,2; a new delay_sel applies immediately
        en = 1'b0;
        delay_sel = 4'd2;
        #1;
        checks++;
        if (dout !== 8'h08 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL delay_resel got=%h/%b exp=08/1", dout, dout_valid);
        end
    endtask

    task automatic test_enable_gap();
        exp_t e;
        do_reset();
        mode = MODE_REG;
        en = 1'b1;
        din = 8'h10; tick();
        din = 8'h20; tick();
        en = 1'b0; din = 8'h77;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{8'h20, 1'b1, 8'h01});
            tick();
            e = sb.pop_front();
            checks++;
            if (dout !== e.dout || chg_count !== e.cnt) begin
                errors++;
                $display("FAIL gap i=%0d got=%h cnt=%0d exp=%h cnt=%0d",
                         i, dout, chg_count, e.dout, e.cnt);
            end
        end
        en = 1'b1;
        sb.push_back('{8'h77, 1'b1, 8'h02});
        tick();
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || chg_count !== e.cnt) begin
            errors++;
            $display("FAIL gap_resume got=%h cnt=%0d exp=%h cnt=%0d",
                     dout, chg_count, e.dout, e.cnt);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        do_reset();
        mode = MODE_REG;
        en = 1'b1; din = 8'h5A; tick();
        en = 1'b0; tick();
        mode = MODE_HOLD;
        en = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            din = 8'(v);
            sb.push_back('{8'h5A, 1'b1, 8'(v)});
            tick();
            e = sb.pop_front();
            checks++;
            if (dout !== e.dout || dout_valid !== e.valid
                || chg_count !== e.cnt) begin
                errors++;
                $display("FAIL hold v=%0d got=%h/%b cnt=%0d exp=%h/%b cnt=%0d",
                         v, dout, dout_valid, chg_count,
                         e.dout, e.valid, e.cnt);
            end
        end
        en = 1'b0;
        mode = MODE_REG;
        #1;
        checks++;
        if (dout !== 8'h05 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_exit got=%h/%b exp=05/1", dout, dout_valid);
        end
    endtask

    task automatic test_change();
        exp_t e;
        logic [7:0] seq[3] = '{8'h0F, 8'hF0, 8'hF0};
        exp_t exp_tab[3] = '{'{8'h0F, 1'b0, 8'h00},
                             '{8'hFF, 1'b1, 8'h01},
                             '{8'h00, 1'b1, 8'h01}};
        do_reset();
        mode = MODE_CHANGE;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = seq[i];
            sb.push_back(exp_tab[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (dout !== e.dout || dout_valid !== e.valid
                || chg_count !== e.cnt) begin
                errors++;
                $display("FAIL change i=%0d got=%h/%b cnt=%0d exp=%h/%b cnt=%0d",
                         i, dout, dout_valid, chg_count,
                         e.dout, e.valid, e.cnt);
            end
        end
    endtask

    task automatic test_counter();
        do_reset();
        mode = MODE_REG;
        en = 1'b1;
        for (int v = 0; v <= 5; v++) begin
            din = 8'(v);
            tick();
        end
        checks++;
        if (chg_count2 !== 2'd3) begin
            errors++;
            $display("FAIL cnt_sat got=%0d exp=3", chg_count2);
        end
        checks++;
        if (chg_count !== 8'd5) begin
            errors++;
            $display("FAIL cnt_wide got=%0d exp=5", chg_count);
        end
        checks++;
        if (dout2 !== 8'h05 || dout_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL cnt_dout2 got=%h/%b exp=05/1", dout2, dout_valid2);
        end
        clr_count = 1'b1; din = 8'h06; tick();
        clr_count = 1'b0;
        checks++;
        if (chg_count !== 8'd0 || chg_count2 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clr got=%0d/%0d exp=0/0", chg_count, chg_count2);
        end
        din = 8'h07; tick();
        checks++;
        if (chg_count !== 8'd1) begin
            errors++;
            $display("FAIL cnt_after_clr got=%0d exp=1", chg_count);
        end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_enable_gap();
        test_hold();
        test_change();
        test_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
